reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  Architectural register file with rename (busy/tag) table, directly downstream of the ROB commit port.
//  Decoder marks rd as pending on a ROB tag; ROB commit writes value and releases the tag.
//  Two combinational read ports give the decoder/RS either a value or the ROB tag to wait on.
//  A ROB clear (mispredict) drops all pending renames in one cycle.
// PARAMETERS
//  ROB_WIDTH  4   ROB tag width. Must match rob.
//  REG_NUM    32  architectural registers. x0 hardwired to zero.
// PORTS
//  clk_in             in   1          clock; all state updates on posedge
//  rst_in             in   1          reset, synchronous, active-high
//  rdy_in             in   1          global enable; low = hold all state
//  clear              in   1          ROB flush
//  from_rob           in   1          commit write valid
//  from_rob_rd        in   5          commit destination
//  from_rob_tag       in   ROB_WIDTH  ROB tag of committing entry
//  from_rob_wdata     in   32         commit value
//  from_decoder       in   1          rename valid
//  from_decoder_rd    in   5          renamed destination
//  from_decoder_tag   in   ROB_WIDTH  ROB tag allocated to it
//  rs1_addr, rs2_addr in   5          read addresses
//  rs1_busy, rs2_busy out  1          operand pending in ROB
//  rs1_tag, rs2_tag   out  ROB_WIDTH  producer tag; valid when busy=1
//  rs1_val, rs2_val   out  32         register value; valid when busy=0
// BEHAVIOUR
//  - Reset (rst_in=1 at posedge, rdy_in=1): all regs=0, busy=0, tag=0; wins over every other input.
//  - rdy_in=0: no state change; read outputs still track current state.
//  - Reads combinational, zero latency. addr 0 -> val=0, busy=0, tag=0 always.
//  - Commit (from_rob=1, rd!=0): reg[rd]<=wdata next edge. busy[rd]<=0 only if
//    tag[rd]==from_rob_tag and no rename of same rd this cycle (else a newer producer owns rd).
//  - Commit is applied even when clear=1 (ROB raises clear with the jump-and-link write).
//  - Rename (from_decoder=1, rd!=0, clear=0): busy[rd]<=1, tag[rd]<=from_decoder_tag next edge.
//  - clear=1: all busy<=0 next edge; rename in the same cycle ignored; tags need not reset.
//  - Same-cycle rename and commit to same rd: value written, busy stays/becomes 1 with new tag.
//  - Writes/renames to x0 discarded silently.
//  - Read of rd being renamed this cycle returns pre-rename state (decoder orders its own
//    rs-before-rd dependence).
//  - No internal FSM; per-register state is {val, busy, tag}.
// CONFIGURATION
//  REG_FILE_BYPASS_EN defined: read port whose addr==from_rob_rd, from_rob=1, busy=1 and
//    tag==from_rob_tag returns busy=0, val=from_rob_wdata in the same cycle (commit forwarding).
//  Not defined: reads see committed value one cycle after commit (busy=1 during commit cycle).
// STRUCTURE
//  Shared package riscv_pkg: REG_NUM, ROB_WIDTH, REG_ZERO=5'd0, tag typedef rob_tag_t,
//    word typedef word_t; same package used by rob/rs/lsb.
//  One sub-module: reg_file_read_port (lookup + x0 masking + optional bypass), instanced x2.
// TESTING
//  1 reset, read x5 -> val=0 busy=0; rename x5 tag 3, read -> busy=1 tag=3.
//  2 after 1: commit rd=5 tag=3 wdata=0x1234 -> next cycle val=0x1234 busy=0;
//    with BYPASS_EN the same read in commit cycle already shows 0x1234 busy=0.
//  3 rename x7 tag 2, rename x7 tag 4, commit rd=7 tag=2 wdata=9 -> val=9, busy=1, tag=4.
//  4 same-cycle rename x8 tag 6 + commit rd=8 tag=5 -> val=commit data, busy=1 tag=6.
//  5 rename x1,x2 tags 1,2; clear=1 with commit rd=1 tag=1 wdata=0x80 and rename x3 ->
//    x1=0x80, busy x1/x2/x3 all 0.
//  6 write/rename x0 -> read x0 stays val=0 busy=0; rdy_in=0 with commit -> no change;
//    rst_in mid-stream -> all busy=0, vals=0 next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types: register/ROB widths, tag and word types.
// Used by reg_file and by the rob/rs/lsb blocks.
package riscv_pkg;

    localparam int unsigned ROB_WIDTH  = 4;
    localparam int unsigned REG_NUM    = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef logic [ROB_WIDTH-1:0]  rob_tag_t;
    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_if.sv
// Register file bus: ROB commit, decoder rename and the two operand read ports.
interface reg_file_if;
    import riscv_pkg::*;

    logic      rdy_in;
    logic      clear;
    logic      from_rob;
    reg_addr_t from_rob_rd;
    rob_tag_t  from_rob_tag;
    word_t     from_rob_wdata;
    logic      from_decoder;
    reg_addr_t from_decoder_rd;
    rob_tag_t  from_decoder_tag;
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    logic      rs1_busy;
    logic      rs2_busy;
    rob_tag_t  rs1_tag;
    rob_tag_t  rs2_tag;
    word_t     rs1_val;
    word_t     rs2_val;

    modport master (
        output rdy_in, clear,
        output from_rob, from_rob_rd, from_rob_tag, from_rob_wdata,
        output from_decoder, from_decoder_rd, from_decoder_tag,
        output rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_val, rs2_val
    );

    modport slave (
        input  rdy_in, clear,
        input  from_rob, from_rob_rd, from_rob_tag, from_rob_wdata,
        input  from_decoder, from_decoder_rd, from_decoder_tag,
        input  rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_val, rs2_val
    );

endinterface

// File: rtl/reg_file_read_port.sv
// Combinational operand lookup with x0 masking.
// REG_FILE_BYPASS_EN adds same-cycle forwarding of a matching ROB commit.
module reg_file_read_port
    import riscv_pkg::*;
(
    input  reg_addr_t addr,
    input  word_t     regs     [REG_NUM],
    input  logic      busy_tab [REG_NUM],
    input  rob_tag_t  tag_tab  [REG_NUM],
`ifdef REG_FILE_BYPASS_EN
    input  logic      commit,
    input  reg_addr_t commit_rd,
    input  rob_tag_t  commit_tag,
    input  word_t     commit_wdata,
`endif
    output logic      busy,
    output rob_tag_t  tag,
    output word_t     val
);

    always_comb begin
        busy = 1'b0;
        tag  = '0;
        val  = '0;
        if (addr != REG_ZERO) begin
            busy = busy_tab[addr];
            tag  = tag_tab[addr];
            val  = regs[addr];
`ifdef REG_FILE_BYPASS_EN
            // Committing producer is the one this operand waits on: forward its data now.
            if (commit && (commit_rd == addr) && busy_tab[addr] && (tag_tab[addr] == commit_tag)) begin
                busy = 1'b0;
                val  = commit_wdata;
            end
`endif
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with busy/tag rename table behind the ROB commit port.
// Optional commit forwarding on the read ports: define REG_FILE_BYPASS_EN.
module reg_file
    import riscv_pkg::*;
(
    input logic         clk_in,
    input logic         rst_in,
    reg_file_if.slave   bus
);

    word_t    regs     [REG_NUM];
    logic     busy_tab [REG_NUM];
    rob_tag_t tag_tab  [REG_NUM];

    logic [REG_NUM-1:0] commit_hit;
    logic [REG_NUM-1:0] rename_hit;
    logic [REG_NUM-1:0] release_hit;

    // Per-register decode; x0 never hits. A same-cycle rename keeps ownership with the newer producer.
    always_comb begin
        commit_hit  = '0;
        rename_hit  = '0;
        release_hit = '0;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            commit_hit[i]  = bus.from_rob && (bus.from_rob_rd == REG_ADDR_W'(i));
            rename_hit[i]  = bus.from_decoder && !bus.clear && (bus.from_decoder_rd == REG_ADDR_W'(i));
            release_hit[i] = commit_hit[i] && (tag_tab[i] == bus.from_rob_tag) && !rename_hit[i];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs[i]     <= '0;
                busy_tab[i] <= 1'b0;
                tag_tab[i]  <= '0;
            end
        end else if (bus.rdy_in) begin
            for (int unsigned i = 1; i < REG_NUM; i++) begin
                if (commit_hit[i]) begin
                    regs[i] <= bus.from_rob_wdata;
                end
                if (bus.clear) begin
                    busy_tab[i] <= 1'b0;
                end else if (rename_hit[i]) begin
                    busy_tab[i] <= 1'b1;
                    tag_tab[i]  <= bus.from_decoder_tag;
                end else if (release_hit[i]) begin
                    busy_tab[i] <= 1'b0;
                end
            end
        end
    end

    reg_file_read_port u_rs1 (
        .addr         (bus.rs1_addr),
        .regs         (regs),
        .busy_tab     (busy_tab),
        .tag_tab      (tag_tab),
`ifdef REG_FILE_BYPASS_EN
        .commit       (bus.from_rob),
        .commit_rd    (bus.from_rob_rd),
        .commit_tag   (bus.from_rob_tag),
        .commit_wdata (bus.from_rob_wdata),
`endif
        .busy         (bus.rs1_busy),
        .tag          (bus.rs1_tag),
        .val          (bus.rs1_val)
    );

    reg_file_read_port u_rs2 (
        .addr         (bus.rs2_addr),
        .regs         (regs),
        .busy_tab     (busy_tab),
        .tag_tab      (tag_tab),
`ifdef REG_FILE_BYPASS_EN
        .commit       (bus.from_rob),
        .commit_rd    (bus.from_rob_rd),
        .commit_tag   (bus.from_rob_tag),
        .commit_wdata (bus.from_rob_wdata),
`endif
        .busy         (bus.rs2_busy),
        .tag          (bus.rs2_tag),
        .val          (bus.rs2_val)
    );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: directed scenarios plus random traffic against a reference model.
module tb_reg_file;
    import riscv_pkg::*;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] val;
        bit          busy;
        logic [3:0]  tag;
        bit          chk_tag;
    } exp_t;

    logic clk;
    logic rst;
    reg_file_if bus();

    reg_file dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference architectural state
    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [3:0]  m_tag  [32];
    bit          model_valid = 1'b0;

    exp_t q[$];
    exp_t pend[$];
    event sample_ev;
    int   vectors    = 0;
    int   miscompares = 0;

    function automatic exp_t model_read(input string name, input int port, input int a);
        exp_t e;
        e.name = name;
        e.port = port;
        e.val = '0; e.busy = 1'b0; e.tag = '0; e.chk_tag = 1'b1;
        if (a != 0) begin
            e.val  = m_val[a];
            e.busy = m_busy[a];
            e.tag  = m_tag[a];
`ifdef REG_FILE_BYPASS_EN
            if (bus.from_rob && int'(bus.from_rob_rd) == a && m_busy[a] && m_tag[a] == bus.from_rob_tag) begin
                e.busy = 1'b0;
                e.val  = bus.from_rob_wdata;
            end
`endif
            e.chk_tag = e.busy;
        end
        return e;
    endfunction

    task automatic model_update();
        int crd, drd;
        bit owned_by_new;
        crd = int'(bus.from_rob_rd);
        drd = int'(bus.from_decoder_rd);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
            model_valid = 1'b1;
        end else if (bus.rdy_in) begin
            owned_by_new = bus.from_decoder && !bus.clear && drd == crd;
            if (bus.from_rob && crd != 0) begin
                m_val[crd] = bus.from_rob_wdata;
                if (m_tag[crd] == bus.from_rob_tag && !owned_by_new) m_busy[crd] = 1'b0;
            end
            if (bus.clear) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (bus.from_decoder && drd != 0) begin
                m_busy[drd] = 1'b1;
                m_tag[drd]  = bus.from_decoder_tag;
            end
        end
    endtask

    task automatic want(input string name, input int port, input logic [31:0] val,
                        input bit busy, input logic [3:0] tag, input bit chk_tag);
        exp_t e;
        e.name = name; e.port = port; e.val = val; e.busy = busy; e.tag = tag; e.chk_tag = chk_tag;
        pend.push_back(e);
    endtask

    // One cycle: inputs already driven after negedge; expectations sampled before the posedge.
    task automatic step();
        #1;
        if (model_valid) begin
            q.push_back(model_read("rs1_model", 1, int'(bus.rs1_addr)));
            q.push_back(model_read("rs2_model", 2, int'(bus.rs2_addr)));
        end
        foreach (pend[i]) q.push_back(pend[i]);
        pend.delete();
        -> sample_ev;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.rdy_in = 1'b1;
        bus.clear = 1'b0;
        bus.from_rob = 1'b0;
        bus.from_decoder = 1'b0;
    endtask

    task automatic commit(input int rd, input int tag, input logic [31:0] wdata);
        bus.from_rob = 1'b1;
        bus.from_rob_rd = 5'(rd);
        bus.from_rob_tag = 4'(tag);
        bus.from_rob_wdata = wdata;
    endtask

    task automatic rename(input int rd, input int tag);
        bus.from_decoder = 1'b1;
        bus.from_decoder_rd = 5'(rd);
        bus.from_decoder_tag = 4'(tag);
    endtask

    // Monitor: the read ports present a response every cycle
    initial begin
        exp_t e;
        logic [31:0] v;
        logic b;
        logic [3:0] t;
        forever begin
            @(sample_ev);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.port == 1) begin v = bus.rs1_val; b = bus.rs1_busy; t = bus.rs1_tag; end
                else             begin v = bus.rs2_val; b = bus.rs2_busy; t = bus.rs2_tag; end
                vectors++;
                if (v !== e.val || b !== e.busy || (e.chk_tag && t !== e.tag)) begin
                    miscompares++;
                    $display("FAIL %s port%0d: got val=%h busy=%b tag=%0d, want val=%h busy=%0b tag=%0d",
                             e.name, e.port, v, b, t, e.val, e.busy, e.tag);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.from_rob_rd = '0; bus.from_rob_tag = '0; bus.from_rob_wdata = '0;
        bus.from_decoder_rd = '0; bus.from_decoder_tag = '0;
        bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd0;
        rst = 1'b1;
        @(negedge clk);
        step();
        idle();

        want("t1_reset_x5", 1, 32'h0, 1'b0, 4'd0, 1'b0);
        step();
        rename(5, 3); step(); idle();
        want("t1_renamed_x5", 1, 32'h0, 1'b1, 4'd3, 1'b1);
        step();

        commit(5, 3, 32'h1234);
`ifdef REG_FILE_BYPASS_EN
        want("t2_commit_cycle", 1, 32'h1234, 1'b0, 4'd0, 1'b0);
`else
        want("t2_commit_cycle", 1, 32'h0, 1'b1, 4'd3, 1'b1);
`endif
        step(); idle();
        want("t2_after_commit", 1, 32'h1234, 1'b0, 4'd0, 1'b0);
        step();

        bus.rs1_addr = 5'd7;
        rename(7, 2); step();
        rename(7, 4); step(); idle();
        commit(7, 2, 32'd9); step(); idle();
        want("t3_stale_commit", 1, 32'd9, 1'b1, 4'd4, 1'b1);
        step();

        bus.rs1_addr = 5'd8;
        rename(8, 6); commit(8, 5, 32'h55); step(); idle();
        want("t4_same_cycle", 1, 32'h55, 1'b1, 4'd6, 1'b1);
        step();

        rename(1, 1); step();
        rename(2, 2); step(); idle();
        bus.clear = 1'b1; commit(1, 1, 32'h80); rename(3, 7); step(); idle();
        bus.rs1_addr = 5'd1; bus.rs2_addr = 5'd2;
        want("t5_clear_x1", 1, 32'h80, 1'b0, 4'd0, 1'b0);
        want("t5_clear_x2", 2, 32'h0, 1'b0, 4'd0, 1'b0);
        step();
        bus.rs1_addr = 5'd3;
        want("t5_clear_x3", 1, 32'h0, 1'b0, 4'd0, 1'b0);
        step();

        commit(0, 1, 32'hff); rename(0, 5); step(); idle();
        bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
        want("t6_x0_rs1", 1, 32'h0, 1'b0, 4'd0, 1'b1);
        want("t6_x0_rs2", 2, 32'h0, 1'b0, 4'd0, 1'b1);
        step();
        bus.rdy_in = 1'b0; commit(5, 0, 32'hdead); rename(9, 1);
        bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd9;
        step(); idle();
        want("t6_hold_x5", 1, 32'h1234, 1'b0, 4'd0, 1'b0);
        want("t6_hold_x9", 2, 32'h0, 1'b0, 4'd0, 1'b0);
        step();

        // Random traffic on a narrow register window to force collisions
        for (int n = 0; n < 600; n++) begin
            int rd;
            rst = ($urandom_range(0, 149) == 0);
            bus.rdy_in = ($urandom_range(0, 9) != 0);
            bus.clear = ($urandom_range(0, 15) == 0);
            bus.from_rob = $urandom_range(0, 1) == 1;
            rd = $urandom_range(0, 9);
            bus.from_rob_rd = 5'(rd);
            bus.from_rob_tag = ($urandom_range(0, 1) == 1) ? m_tag[rd] : 4'($urandom);
            bus.from_rob_wdata = $urandom;
            bus.from_decoder = $urandom_range(0, 1) == 1;
            bus.from_decoder_rd = 5'($urandom_range(0, 9));
            bus.from_decoder_tag = 4'($urandom);
            bus.rs1_addr = 5'($urandom_range(0, 9));
            bus.rs2_addr = 5'($urandom_range(0, 9));
            step();
        end

        idle();
        bus.from_decoder = 1'b1; bus.from_decoder_rd = 5'd4; bus.from_decoder_tag = 4'd9;
        step(); idle();
        rst = 1'b1; step(); idle();
        bus.rs1_addr = 5'd1; bus.rs2_addr = 5'd4;
        want("t6_rst_x1", 1, 32'h0, 1'b0, 4'd0, 1'b0);
        want("t6_rst_x4", 2, 32'h0, 1'b0, 4'd0, 1'b0);
        step();

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
